// File: rtl/chacha_stream.sv
// ChaCha keystream generator: produces num_blocks 64-byte keystream blocks from key/nonce/counter,
// iterating UNROLL half-rounds per cycle and presenting each block through a valid/ready register.
module chacha_stream #(
    parameter int ROUNDS = 20,
    parameter int UNROLL = 1,
    parameter int IETF   = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [63:0]  counter,
    input  logic [15:0]  num_blocks,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic         out_last,
    output logic         wrap_err
);
    typedef logic [15:0][31:0] state_t;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

    localparam int         CYCLES   = ROUNDS / UNROLL;
    localparam logic [4:0] LAST_RND = 5'(CYCLES - 1);

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    // One column (diag=0) or diagonal (diag=1) half-round: four quarter-rounds.
    function automatic state_t half_round(input state_t s, input logic diag);
        state_t      r;
        logic [3:0]  a, b, c, d;
        logic [31:0] wa, wb, wc, wd;
        int          sh;
        r  = s;
        sh = diag ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            a  = 4'(i);
            b  = 4'(4 + ((i + sh) % 4));
            c  = 4'(8 + ((i + 2 * sh) % 4));
            d  = 4'(12 + ((i + 3 * sh) % 4));
            wa = r[a]; wb = r[b]; wc = r[c]; wd = r[d];
            wa = wa + wb; wd = rotl(wd ^ wa, 16);
            wc = wc + wd; wb = rotl(wb ^ wc, 12);
            wa = wa + wb; wd = rotl(wd ^ wa, 8);
            wc = wc + wd; wb = rotl(wb ^ wc, 7);
            r[a] = wa; r[b] = wb; r[c] = wc; r[d] = wd;
        end
        return r;
    endfunction

    function automatic state_t build_state(input logic [255:0] k, input logic [95:0] n,
                                           input logic [63:0] ctr);
        state_t s;
        s[0] = 32'h61707865;
        s[1] = 32'h3320646e;
        s[2] = 32'h79622d32;
        s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = bswap(k[255-32*i -: 32]);
        s[12] = ctr[31:0];
        if (IETF != 0) begin
            for (int i = 0; i < 3; i++) s[13+i] = bswap(n[95-32*i -: 32]);
        end else begin
            s[13] = ctr[63:32];
            s[14] = bswap(n[63:32]);
            s[15] = bswap(n[31:0]);
        end
        return s;
    endfunction

    fsm_t         r_state, w_next_state;
    state_t       r_init, r_work;
    logic [63:0]  r_ctr;
    logic [15:0]  r_left;
    logic [4:0]   r_rnd;
    logic         r_out_valid, r_out_last, r_wrap_err;
    logic [511:0] r_out_data;

    logic         w_busy, w_accept, w_write, w_ctr_wrap, w_last_blk;
    logic [63:0]  w_ctr_next;
    state_t       w_round, w_next_init;
    logic [511:0] w_block;

    assign w_busy     = (r_state != IDLE) || r_out_valid;
    assign w_accept   = start && !w_busy && (num_blocks != 16'd0);
    assign w_write    = (r_state == FINAL) && (!r_out_valid || out_ready);
    // With a 32-bit counter the block at 0xFFFFFFFF ends the stream early.
    assign w_ctr_wrap = (IETF != 0) && (r_ctr[31:0] == 32'hFFFF_FFFF);
    assign w_last_blk = (r_left == 16'd1) || w_ctr_wrap;
    assign w_ctr_next = r_ctr + 64'd1;

    always_comb begin
        if (UNROLL == 2) w_round = half_round(half_round(r_work, 1'b0), 1'b1);
        else             w_round = half_round(r_work, r_rnd[0]);
    end

    always_comb begin
        w_next_init     = r_init;
        w_next_init[12] = w_ctr_next[31:0];
        if (IETF == 0) w_next_init[13] = w_ctr_next[63:32];
    end

    always_comb begin
        w_block = '0;
        for (int i = 0; i < 16; i++) w_block[511-32*i -: 32] = bswap(r_init[i] + r_work[i]);
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next_state = ROUND;
            ROUND:   if (r_rnd == LAST_RND) w_next_state = FINAL;
            FINAL:   if (w_write) w_next_state = w_last_blk ? IDLE : ROUND;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: the working state, counter and round index are always loaded on an accepted
    // start before use, so they carry no reset; only the FSM and visible outputs do.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_init <= build_state(key, nonce, counter);
            r_work <= build_state(key, nonce, counter);
            r_ctr  <= counter;
            r_left <= num_blocks;
            r_rnd  <= '0;
        end else if (r_state == ROUND) begin
            r_work <= w_round;
            r_rnd  <= (r_rnd == LAST_RND) ? 5'd0 : r_rnd + 5'd1;
        end else if (w_write && !w_last_blk) begin
            r_init <= w_next_init;
            r_work <= w_next_init;
            r_ctr  <= w_ctr_next;
            r_left <= r_left - 16'd1;
            r_rnd  <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_wrap_err  <= 1'b0;
        end else begin
            if (w_accept) r_wrap_err <= 1'b0;
            if (w_write) begin
                r_out_data  <= w_block;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_blk;
                if (w_ctr_wrap && (r_left != 16'd1)) r_wrap_err <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign wrap_err  = r_wrap_err;
endmodule
